// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared constants and state encoding for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

  localparam int unsigned N_DEF = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StLoad  = ST_LOAD
  } state_e;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial input, control and parallel output handshake bundle for sipo_frame_ctrl.
interface sipo_frame_ctrl_if
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
);

  logic         start;
  logic         si_valid;
  logic         si;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;

  // master: bit source plus downstream consumer; slave: the controller
  modport master (
    output start, si_valid, si, out_ready,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  start, si_valid, si, out_ready,
    output out_data, out_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_frame_ctrl_shreg.sv
// N-bit right-shifting serial-in register; first bit in ends up at q[0].
module sipo_shreg
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         si,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = {si, q_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer: counts N qualified serial bits after start, then moves the word
// into a valid/ready holding register, flagging words dropped while it is full.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic             clk,
  input  logic             reset,
  sipo_frame_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [N-1:0]     sreg;
  logic             sh_clr, sh_en;

  sipo_shreg #(
    .N (N)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .clr   (sh_clr),
    .en    (sh_en),
    .si    (bus.si),
    .q     (sreg)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    sh_clr      = 1'b0;
    sh_en       = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      StShift: begin
        if (bus.si_valid) begin
          sh_en = 1'b1;
          // Leave SHIFT on the Nth bit so the count never wraps past N-1
          if (cnt_q == LastCnt) begin
            state_d = StLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StLoad: begin
        state_d = StIdle;
        // A word consumed on this edge frees the holding register for the new one
        if (!out_valid_q || bus.out_ready) begin
          out_data_d  = sreg;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: directed frames push expected words, a monitor
// pops and compares on every handshake transfer; control flags are checked inline.
module tb_sipo_frame_ctrl;
  import sipo_ctrl_pkg::*;

  localparam int unsigned N = N_DEF;

  logic clk = 1'b0;
  logic reset;

  sipo_frame_ctrl_if #(.N(N)) bus ();

  sipo_frame_ctrl #(
    .N (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start cycle drives a qualified bit that must be ignored; gaps carry junk bits
  // and start pulses that must also be ignored. Returns just after the Nth-bit edge.
  task automatic send_frame(input logic [N-1:0] w, input bit gap);
    bus.start    = 1'b1;
    bus.si_valid = 1'b1;
    bus.si       = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      bus.si       = w[i];
      bus.si_valid = 1'b1;
      step();
      if (gap && i != int'(N) - 1) begin
        bus.si_valid = 1'b0;
        bus.si       = ~w[i];
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
      end
    end
    bus.si_valid = 1'b0;
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and ready
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
      end else begin
        chk("xfer_word", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.si_valid = 1'b0;
    bus.si       = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_overrun",   32'(bus.overrun),   32'h0);
    reset = 1'b0;

    // Serial activity without start must be ignored
    for (int i = 0; i < 6; i++) begin
      bus.si       = i[0];
      bus.si_valid = (i % 3 != 0);
      step();
    end
    bus.si_valid = 1'b0;
    chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
    chk("idle_busy",      32'(bus.busy),      32'h0);
    chk("idle_out_data",  32'(bus.out_data),  32'h0);

    // Basic frame: bits 1,0,1,1,0 -> 5'b01101
    exp_q.push_back(5'b01101);
    send_frame(5'b01101, 1'b0);
    chk("basic_load_busy",  32'(bus.busy),      32'h1);
    chk("basic_load_valid", 32'(bus.out_valid), 32'h0);
    step();
    chk("basic_valid", 32'(bus.out_valid), 32'h1);
    chk("basic_data",  32'(bus.out_data),  32'h0d);
    chk("basic_busy",  32'(bus.busy),      32'h0);
    step();
    chk("basic_consumed", 32'(bus.out_valid), 32'h0);

    // Gapped bits with start pulses during SHIFT
    exp_q.push_back(5'b01101);
    send_frame(5'b01101, 1'b1);
    chk("gap_load_busy", 32'(bus.busy), 32'h1);
    step();
    chk("gap_valid", 32'(bus.out_valid), 32'h1);
    chk("gap_data",  32'(bus.out_data),  32'h0d);
    chk("gap_busy",  32'(bus.busy),      32'h0);
    step();

    // Backpressure then overrun
    bus.out_ready = 1'b0;
    exp_q.push_back(5'b11111);
    send_frame(5'b11111, 1'b0);
    step();
    chk("bp_valid",   32'(bus.out_valid), 32'h1);
    chk("bp_data",    32'(bus.out_data),  32'h1f);
    chk("bp_overrun", 32'(bus.overrun),   32'h0);
    send_frame(5'b10000, 1'b0);
    step();
    chk("ovr_valid",     32'(bus.out_valid), 32'h1);
    chk("ovr_data_held", 32'(bus.out_data),  32'h1f);
    chk("ovr_flag",      32'(bus.overrun),   32'h1);
    bus.out_ready = 1'b1;
    step();
    chk("ovr_drained_valid", 32'(bus.out_valid), 32'h0);
    chk("ovr_sticky",        32'(bus.overrun),   32'h1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_overrun", 32'(bus.overrun), 32'h0);

    // Consume and load on the same edge
    bus.out_ready = 1'b0;
    exp_q.push_back(5'b11111);
    send_frame(5'b11111, 1'b0);
    step();
    exp_q.push_back(5'b00001);
    send_frame(5'b00001, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk("sim_valid",   32'(bus.out_valid), 32'h1);
    chk("sim_data",    32'(bus.out_data),  32'h01);
    chk("sim_overrun", 32'(bus.overrun),   32'h0);
    step();
    chk("sim_consumed", 32'(bus.out_valid), 32'h0);

    // Reset after 3 of 5 bits discards the partial frame
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.si       = 1'b1;
      bus.si_valid = 1'b1;
      step();
    end
    bus.si_valid = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy",  32'(bus.busy),      32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    exp_q.push_back(5'b01010);
    send_frame(5'b01010, 1'b0);
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_data",  32'(bus.out_data),  32'h0a);
    step();
    step();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Controller that sequences an N-bit serial-in/parallel-out shift register.
- Accepts a start pulse, counts N qualified serial bits, and moves the assembled word into an output holding register.
- Presents the word downstream over a valid/ready handshake and flags words lost to a full holding register.
- Sits between a serial bit source (line receiver, bit-bang input) and any parallel consumer.

Parameters:
- N, 5, word width in bits and number of serial bits per frame; legal range 2..32.
- CNT_W, $clog2(N+1), bit-counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame-start request; honoured only in IDLE.
- si_valid  input  1  qualifies si this cycle.
- si  input  1  serial data bit.
- out_data  output  N  assembled word (holding register).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when out_valid=1.
- busy  output  1  high in SHIFT and LOAD.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (reset=1 at a rising edge), from any state including mid-frame:
  - state=IDLE, shift register=0, bit count=0.
  - out_data=0, out_valid=0, busy=0, overrun=0.
  - A partial frame is discarded.
- States: IDLE, SHIFT, LOAD. busy is registered: 1 exactly when state is SHIFT or LOAD.
- IDLE:
  - start=1 -> SHIFT, count=0, shift register cleared to 0.
  - si/si_valid are ignored in IDLE, including the start cycle.
- SHIFT, on each edge with si_valid=1:
  - Right shift: sreg <= {si, sreg[N-1:1]}; count <= count+1.
  - The first bit received ends at sreg[0] and the last at sreg[N-1].
  - si_valid=0: hold sreg and count.
  - When si_valid=1 and count==N-1, this is the Nth bit -> LOAD.
  - start is ignored.
- LOAD, lasting exactly one cycle, then -> IDLE:
  - out_valid=0, or out_valid=1 with out_ready=1: out_data<=sreg, out_valid<=1.
  - out_valid=1 with out_ready=0: out_data is unchanged, the new word is dropped, overrun<=1.
  - start and si_valid are ignored.
- Latency and throughput:
  - Nth-bit sampling edge at cycle k -> out_valid high after edge k+1.
  - Minimum frame spacing is N+2 cycles: start, N bits, LOAD.
- Handshake:
  - Transfer occurs on any edge with out_valid=1 and out_ready=1.
  - out_valid clears on that edge unless LOAD loads a new word on the same edge, in which case it stays 1.
  - out_data is stable while out_valid=1 and no transfer occurs.
  - out_ready with out_valid=0 has no effect.
- overrun clears only on reset.
- The count never exceeds N-1; no wrap-around occurs because the FSM leaves SHIFT at N-1.

Decomposition:
- Package sipo_ctrl_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_LOAD=2'd2.
  - Default width constant N_DEF=5.
- Sub-module sipo_shreg:
  - Parameter N; ports clk, reset, clr, en, si, q[N-1:0].
  - Same-cycle priority: reset > clr > en.
  - Instantiated once.
- FSM, counter, holding register and flags stay in the top level.

Test Plan:
- Reset then idle: hold reset 2 cycles, toggle si/si_valid without start -> out_valid=0, busy=0, out_data=5'b00000.
- Basic frame: start, then bits 1,0,1,1,0 on consecutive cycles with si_valid=1 and out_ready=1 -> out_data=5'b01101 with out_valid high one cycle after the 5th bit; busy falls after LOAD.
- Gapped bits: same bits with si_valid=0 inserted between each bit -> identical out_data=5'b01101; start pulses during SHIFT ignored.
- Backpressure/overrun:
  - out_ready=0; frame 1,1,1,1,1 -> out_data=5'b11111, out_valid=1.
  - Second frame 0,0,0,0,1 -> out_data still 5'b11111, overrun=1.
  - Raise out_ready -> out_valid drops; overrun stays 1.
- Simultaneous consume/load: word 5'b11111 pending; out_ready=1 on the LOAD cycle of frame 1,0,0,0,0 -> out_valid stays 1, out_data=5'b00001, overrun=0.
- Reset mid-frame: after 3 of 5 bits assert reset one cycle -> state IDLE, busy=0; new start + 5 bits 0,1,0,1,0 -> out_data=5'b01010 with no stale bits.
